kernel_scheduler: RTL
=====================

KERNEL_SCHEDULER -- requirements
Module: kernel_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the job/result data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 32, meaning the maximum RUN cycles before a job is aborted (must exceed 19).
REQ-004 The block SHALL have a single clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1, the system clock.
REQ-006 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-007 The block SHALL have port req, input, N_REQ, per-requester job pending (level).
REQ-008 The block SHALL have port req_data, input, N_REQ*DATA_W, per-requester job operand; slice i is bits [i*DATA_W +: DATA_W].
REQ-009 The block SHALL have port grant, output, N_REQ, a one-hot one-cycle pulse marking job acceptance.
REQ-010 The block SHALL have port resp_valid, output, N_REQ, a one-hot one-cycle pulse carrying the result to its owner.
REQ-011 The block SHALL have port resp_data, output, DATA_W, the result, valid with resp_valid.
REQ-012 The block SHALL have port resp_err, output, 1, asserted with resp_valid when the job timed out.
REQ-013 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-014 The block SHALL have port k_in_data, output, DATA_W, the operand driven to the kernel.
REQ-015 The block SHALL have port k_in_valid, output, 1, the kernel in_valid (held high for the entire job).
REQ-016 The block SHALL have port k_out_data, input, DATA_W, the kernel result.
REQ-017 The block SHALL have port k_out_valid, input, 1, the kernel result-valid level.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DRAIN, with all outputs registered or decoded from registered state.
REQ-019 IDLE SHALL drive k_in_valid=0; it issues a grant only when |req and k_out_valid==0.
REQ-020 Arbitration SHALL be round-robin: the search starts at last_grant+1 and wraps modulo N_REQ; last_grant resets to N_REQ-1, so requester 0 wins first.
REQ-021 On a grant decision, the block SHALL latch req_data slice, record the owner, update last_grant and move to RUN; grant[owner] SHALL be high in the first RUN cycle only.
REQ-022 RUN SHALL drive k_in_valid=1 and k_in_data=latched operand (stable throughout RUN), and a RUN cycle counter SHALL start at 0.
REQ-023 In RUN with k_out_valid==1, the block SHALL register resp_data=k_out_data, resp_valid[owner]=1, resp_err=0, and move to DRAIN.
REQ-024 In RUN with counter==TIMEOUT-1 and k_out_valid==0, the block SHALL register resp_valid[owner]=1, resp_err=1, resp_data=0, and move to DRAIN.
REQ-025 DRAIN SHALL drive k_in_valid=0 and return to IDLE once k_out_valid==0; DRAIN lasts at least 1 cycle.
REQ-026 Nominal timing with a conforming kernel SHALL be: grant in RUN cycle 0; k_out_valid first seen in RUN cycle 18; resp_valid in the first DRAIN cycle (19 cycles after grant); result = operand+16 mod 2^DATA_W; next grant no earlier than 21 cycles after the previous one.
REQ-027 req SHALL be sampled in IDLE only; a req still high on return to IDLE is a new job, and req_data changes outside IDLE SHALL be ignored.
REQ-028 Simultaneous requests SHALL resolve to exactly one grant per decision; a requester is never granted twice in a row while another is pending.
REQ-029 Counter width SHALL be clog2(TIMEOUT), with no wrap before timeout.

Reset
REQ-030 When rst_n is low, the block SHALL force state=IDLE, last_grant=N_REQ-1, and set grant, resp_valid, resp_err, busy, k_in_valid and k_in_data to 0, immediately and asynchronously.
REQ-031 Reset mid-job SHALL discard the job silently with no resp_valid; after release, at least one IDLE cycle with k_in_valid=0 SHALL precede any RUN.

Verification
REQ-032 Single job: req=0001, data0=0x1234 -> grant=0001 once; 19 cycles later resp_valid=0001, resp_data=0x1244, resp_err=0.
REQ-033 Contention: req=1111 held continuously -> grants occur in order 0,1,2,3,0 at 21-cycle spacing.
REQ-034 Wrap: data=0xFFF8 -> resp_data=0x0008.
REQ-035 Stuck kernel: k_out_valid tied 0 -> resp_valid after 32 RUN cycles with resp_err=1 and resp_data=0, then DRAIN->IDLE, and the next job proceeds.
REQ-036 Reset in RUN cycle 10 -> all outputs 0 asynchronously; no resp_valid; after release, a fresh job from requester 0 completes with the correct result.
REQ-037 Late kernel clear: k_out_valid held 1 for 3 extra cycles -> DRAIN extends and no grant issues until k_out_valid==0.

Source files
------------

// File: rtl/kernel_scheduler.sv
// kernel_scheduler: round-robin job scheduler that feeds one shared kernel and returns its result to the owner.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req, req_data            per-requester job pending level and operand slices
//   grant                    one-hot pulse in the first RUN cycle of an accepted job
//   resp_valid, resp_data    one-hot result pulse to the owner, with result data
//   resp_err                 set with resp_valid when the job timed out
//   busy                     high whenever the scheduler is not idle
//   k_in_data, k_in_valid    operand and valid driven to the kernel for the whole job
//   k_out_data, k_out_valid  kernel result and result-valid level
module kernel_scheduler #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]       resp_data,
    output logic                    resp_err,
    output logic                    busy,
    output logic [DATA_W-1:0]       k_in_data,
    output logic                    k_in_valid,
    input  logic [DATA_W-1:0]       k_out_data,
    input  logic                    k_out_valid
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q;
    logic [IW-1:0]       last_q, owner_q, owner_d;
    logic [CW-1:0]       cnt_q;
    logic [DATA_W-1:0]   op_d, k_in_data_q, resp_data_q;
    logic [N_REQ-1:0]    grant_q, resp_valid_q;
    logic                resp_err_q, k_in_valid_q;

    // Fully unrolled round-robin search: k is the distance past last_q, and the
    // descending k order lets the nearest pending requester overwrite farther ones.
    always_comb begin
        owner_d = last_q;
        op_d    = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            for (int c = 0; c < N_REQ; c++)
                if (last_q == IW'(c) && req[(c + 1 + k) % N_REQ])
                    owner_d = IW'((c + 1 + k) % N_REQ);
        for (int c = 0; c < N_REQ; c++)
            if (owner_d == IW'(c))
                op_d = req_data[c*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= IW'(N_REQ - 1);
            owner_q      <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            k_in_valid_q <= 1'b0;
            k_in_data_q  <= '0;
        end else begin
            grant_q      <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A kernel still presenting a stale result blocks acceptance.
                    if (|req && !k_out_valid) begin
                        owner_q          <= owner_d;
                        last_q           <= owner_d;
                        k_in_data_q      <= op_d;
                        k_in_valid_q     <= 1'b1;
                        cnt_q            <= '0;
                        grant_q[owner_d] <= 1'b1;
                        state_q          <= RUN;
                    end
                end
                RUN: begin
                    if (k_out_valid || cnt_q == CW'(TIMEOUT - 1)) begin
                        resp_valid_q[owner_q] <= 1'b1;
                        resp_err_q            <= !k_out_valid;
                        resp_data_q           <= k_out_valid ? k_out_data : '0;
                        k_in_valid_q          <= 1'b0;
                        state_q               <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DRAIN: state_q <= k_out_valid ? DRAIN : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant      = grant_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign busy       = state_q != IDLE;
    assign k_in_data  = k_in_data_q;
    assign k_in_valid = k_in_valid_q;
endmodule
